// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller:
// state encoding, terminal count and default timing.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [9:0] CNT_MAX          = 10'd999;
    localparam int         TICK_DIV_DEF     = 10_000_000;
    localparam int         DEBOUNCE_CYC_DEF = 2_000_000;

    function automatic logic [9:0] load_val(input logic       down,
                                            input logic [9:0] preset);
        logic [9:0] v;
        v = '0;
        if (down) begin
            v = (preset > CNT_MAX) ? CNT_MAX : preset;
        end
        return v;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus level debouncer that emits a
// one-cycle pulse on an accepted 0->1 transition.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic [1:0]    vld_q;
    logic          armed_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic          accept;

    assign accept  = (sync_q[1] != stable_q) && (cnt_q == CNT_LAST);
    assign press_o = press_q;

    // armed_q blocks a pulse until the key has been seen released
    // after reset, so a key held through reset never fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            vld_q    <= '0;
            armed_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_i};
            vld_q   <= {vld_q[0], 1'b1};
            press_q <= accept && sync_q[1] && armed_q;
            if (vld_q[1] && !sync_q[1]) begin
                armed_q <= 1'b1;
            end
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q    <= '0;
                stable_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/clear keys, up/down
// 0.1 s counter 0..999 and IDLE/RUN/PAUSE/DONE control FSM.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Key_start,
    input  logic        Key_clear,
    input  logic        Mode_down,
    input  logic [9:0]  Preset,
    output logic [15:0] Disp_Data,
    output logic        Running,
    output logic        Done
);

    localparam int            DW       = $clog2(TICK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [9:0]    preset_q;
    logic [DW-1:0] div_q, div_d;
    logic          mode_q;
    logic          run_q, done_q;
    logic          start_p, clear_p;
    logic          in_idle, reload, term;
    logic          src_mode;
    logic [9:0]    src_preset;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .key_i  (Key_start),
        .press_o(start_p)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .key_i  (Key_clear),
        .press_o(clear_p)
    );

    // Live switches matter only in IDLE; elsewhere the sampled copy rules.
    assign in_idle    = (state_q == ST_IDLE);
    assign src_mode   = in_idle ? Mode_down : mode_q;
    assign src_preset = in_idle ? Preset : preset_q;
    assign reload     = in_idle && ((Mode_down != mode_q) || (Preset != preset_q));
    assign term       = mode_q ? (cnt_q == '0) : (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        if (clear_p) begin
            state_d = ST_IDLE;
            cnt_d   = load_val(src_mode, src_preset);
            div_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (reload) begin
                        cnt_d = load_val(Mode_down, Preset);
                        div_d = '0;
                    end
                    if (start_p) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (term) begin
                        state_d = ST_DONE;
                    end else if (start_p) begin
                        state_d = ST_PAUSE;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        cnt_d = mode_q ? cnt_q - 10'd1 : cnt_q + 10'd1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (start_p) state_d = ST_RUN;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            mode_q   <= 1'b0;
            preset_q <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            run_q   <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            if (in_idle) begin
                mode_q   <= Mode_down;
                preset_q <= Preset;
            end
        end
    end

    assign Disp_Data = {6'b0, cnt_q};
    assign Running   = run_q;
    assign Done      = done_q;

endmodule
